// File: rtl/oldland_data_responder_if.sv
// ---------------------------------------------------------------------------
// oldland_data_responder_if
// Pipeline data-bus bundle between the core's data master and a responder.
//   d_access   master -> slave  request valid, held until a response pulse
//   d_addr     master -> slave  30-bit word address
//   d_wr_en    master -> slave  1 = write, 0 = read
//   d_bytesel  master -> slave  byte-lane enables (bit0 = data[7:0])
//   d_wr_val   master -> slave  lane-aligned write data
//   d_data     slave -> master  read data, non-zero only with d_ack on a read
//   d_ack      slave -> master  one-cycle "completed OK" pulse
//   d_error    slave -> master  one-cycle "rejected" pulse
// ---------------------------------------------------------------------------
interface oldland_data_responder_if;
    logic        d_access;
    logic [29:0] d_addr;
    logic        d_wr_en;
    logic [3:0]  d_bytesel;
    logic [31:0] d_wr_val;
    logic [31:0] d_data;
    logic        d_ack;
    logic        d_error;

    modport master (
        output d_access, d_addr, d_wr_en, d_bytesel, d_wr_val,
        input  d_data, d_ack, d_error
    );

    modport slave (
        input  d_access, d_addr, d_wr_en, d_bytesel, d_wr_val,
        output d_data, d_ack, d_error
    );
endinterface

// File: rtl/oldland_data_responder.sv
// ---------------------------------------------------------------------------
// oldland_data_responder
// On-chip RAM responder for the pipeline data bus. Serves word reads and
// byte-lane writes from a 2**addr_bits word array located at base_addr.
// Out-of-window accesses, empty-lane writes and writes to a read-only
// instance are answered with d_error instead of d_ack.
// Ports:
//   clk   clock, all state on posedge
//   rst   asynchronous active-high reset (outputs cleared, array untouched)
//   bus   slave side of the data bus (see oldland_data_responder_if)
//   busy  high while a transaction is in WAIT or RESP
// Timing: request accepted on edge 0 in IDLE; the response pulse is present
// in the cycle after the edge that enters RESP (wait_states + 1 cycles after
// accept); RESP always returns to IDLE, so requests repeat every
// wait_states + 2 cycles at best.
// ---------------------------------------------------------------------------
module oldland_data_responder #(
    parameter int          addr_bits   = 10,
    parameter logic [29:0] base_addr   = 30'h0,
    parameter int          wait_states = 1,
    parameter bit          read_only   = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    oldland_data_responder_if.slave   bus,
    output logic                      busy
);
    localparam int         DEPTH  = 1 << addr_bits;
    localparam logic [3:0] WS_CNT = wait_states[3:0];

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [29:0] addr_reg;
    logic        wr_en_reg;
    logic [3:0]  bytesel_reg;
    logic [31:0] wr_val_reg;
    logic [31:0] d_data_reg;
    logic        d_ack_reg;
    logic        d_error_reg;
    logic        busy_reg;

    // With zero wait states the transaction resolves on the accept edge
    // itself, before the request is latched, so classification and the array
    // port look at the live bus while IDLE and at the latched copy otherwise.
    logic [29:0] cur_addr;
    logic        cur_wr_en;
    logic [3:0]  cur_bytesel;
    logic [31:0] cur_wr_val;
    logic        enter_resp;
    logic        in_window;
    logic        req_ok;
    logic        do_write;
    logic        read_ok;
    logic [addr_bits-1:0] mem_idx;
    logic [31:0] rd_word;

    always_comb begin
        cur_addr    = addr_reg;
        cur_wr_en   = wr_en_reg;
        cur_bytesel = bytesel_reg;
        cur_wr_val  = wr_val_reg;
        if (state_reg == S_IDLE) begin
            cur_addr    = bus.d_addr;
            cur_wr_en   = bus.d_wr_en;
            cur_bytesel = bus.d_bytesel;
            cur_wr_val  = bus.d_wr_val;
        end
    end

    assign enter_resp = ((state_reg == S_IDLE) && bus.d_access && (wait_states == 0)) ||
                        ((state_reg == S_WAIT) && (cnt_reg == 4'd1));

    // The window test on the upper bits also guarantees the index never wraps.
    assign in_window = ((cur_addr >> addr_bits) == (base_addr >> addr_bits));
    assign req_ok    = in_window &&
                       !(cur_wr_en && ((cur_bytesel == 4'b0000) || read_only));
    assign mem_idx   = cur_addr[addr_bits-1:0];
    // Gate with rst so a zero-wait request seen during reset cannot write.
    assign do_write  = enter_resp && req_ok && cur_wr_en && !rst;
    assign read_ok   = enter_resp && req_ok && !cur_wr_en;

    // One byte-wide array per lane keeps the lane enables as plain write
    // enables of independent memories.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (do_write && cur_bytesel[gi]) begin
                    lane_mem[mem_idx] <= cur_wr_val[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[mem_idx];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= 4'd0;
            addr_reg    <= 30'h0;
            wr_en_reg   <= 1'b0;
            bytesel_reg <= 4'h0;
            wr_val_reg  <= 32'h0;
            d_data_reg  <= 32'h0;
            d_ack_reg   <= 1'b0;
            d_error_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            d_ack_reg   <= 1'b0;
            d_error_reg <= 1'b0;
            d_data_reg  <= 32'h0;

            case (state_reg)
                S_IDLE: begin
                    busy_reg <= bus.d_access;
                    if (bus.d_access) begin
                        addr_reg    <= bus.d_addr;
                        wr_en_reg   <= bus.d_wr_en;
                        bytesel_reg <= bus.d_bytesel;
                        wr_val_reg  <= bus.d_wr_val;
                        cnt_reg     <= WS_CNT;
                        state_reg   <= (wait_states == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    busy_reg <= 1'b1;
                    cnt_reg  <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_reg <= S_RESP;
                    end
                end
                S_RESP: begin
                    // The master is still presenting the finished request,
                    // so d_access is not looked at here.
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase

            if (enter_resp) begin
                d_ack_reg   <= req_ok;
                d_error_reg <= !req_ok;
                d_data_reg  <= read_ok ? rd_word : 32'h0;
            end
        end
    end

    assign bus.d_data  = d_data_reg;
    assign bus.d_ack   = d_ack_reg;
    assign bus.d_error = d_error_reg;
    assign busy        = busy_reg;
endmodule

// File: tb/tb_oldland_data_responder.sv
module tb_oldland_data_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy0, busy1, busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oldland_data_responder_if if0();
    oldland_data_responder_if if1();
    oldland_data_responder_if if2();

    // dut 0: defaults; dut 1: read-only, 2 wait states; dut 2: 0 wait states, 256 words at 0x800
    oldland_data_responder #(.addr_bits(10), .base_addr(30'h0), .wait_states(1), .read_only(1'b0))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave), .busy(busy0));
    oldland_data_responder #(.addr_bits(10), .base_addr(30'h0), .wait_states(2), .read_only(1'b1))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .busy(busy1));
    oldland_data_responder #(.addr_bits(8), .base_addr(30'h800), .wait_states(0), .read_only(1'b0))
        u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave), .busy(busy2));

    // Reference model: instance configuration and a byte-granular memory image
    int          cfg_ab   [3] = '{10, 10, 8};
    logic [29:0] cfg_base [3] = '{30'h0, 30'h0, 30'h800};
    int          cfg_ws   [3] = '{1, 2, 0};
    bit          cfg_ro   [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0]  mm_byte  [3][1024][4];
    bit          mm_known [3][1024][4];

    initial begin
        for (int w = 0; w < 3; w++)
            for (int i = 0; i < 1024; i++)
                for (int l = 0; l < 4; l++) mm_known[w][i][l] = 1'b0;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic set_req(input int w, input logic acc, input logic [29:0] a, input logic wr,
                           input logic [3:0] bs, input logic [31:0] v);
        if (w == 0) begin
            if0.d_access = acc; if0.d_addr = a; if0.d_wr_en = wr; if0.d_bytesel = bs; if0.d_wr_val = v;
        end else if (w == 1) begin
            if1.d_access = acc; if1.d_addr = a; if1.d_wr_en = wr; if1.d_bytesel = bs; if1.d_wr_val = v;
        end else begin
            if2.d_access = acc; if2.d_addr = a; if2.d_wr_en = wr; if2.d_bytesel = bs; if2.d_wr_val = v;
        end
    endtask

    function automatic logic get_ack(input int w);
        if (w == 0) return if0.d_ack;
        else if (w == 1) return if1.d_ack;
        else return if2.d_ack;
    endfunction

    function automatic logic get_err(input int w);
        if (w == 0) return if0.d_error;
        else if (w == 1) return if1.d_error;
        else return if2.d_error;
    endfunction

    function automatic logic [31:0] get_data(input int w);
        if (w == 0) return if0.d_data;
        else if (w == 1) return if1.d_data;
        else return if2.d_data;
    endfunction

    function automatic logic get_busy(input int w);
        if (w == 0) return busy0;
        else if (w == 1) return busy1;
        else return busy2;
    endfunction

    // Applies the transaction rules to the model image; returns expected outcome.
    // mask selects the data bits whose value the model can predict.
    task automatic model_apply(input int w, input logic [29:0] a, input logic wr, input logic [3:0] bs,
                               input logic [31:0] v, output logic ok,
                               output logic [31:0] exp_data, output logic [31:0] mask);
        int size;
        int idx;
        size = 1 << cfg_ab[w];
        ok = ((int'(a) / size) == (int'(cfg_base[w]) / size)) && !(wr && (bs == 4'h0 || cfg_ro[w]));
        idx = int'(a) % size;
        exp_data = 32'h0;
        mask = 32'hffff_ffff;
        if (ok && !wr) begin
            mask = 32'h0;
            for (int l = 0; l < 4; l++) begin
                if (mm_known[w][idx][l]) begin
                    exp_data[l*8 +: 8] = mm_byte[w][idx][l];
                    mask[l*8 +: 8] = 8'hff;
                end
            end
        end
        if (ok && wr) begin
            for (int l = 0; l < 4; l++) begin
                if (bs[l]) begin
                    mm_byte[w][idx][l] = v[l*8 +: 8];
                    mm_known[w][idx][l] = 1'b1;
                end
            end
        end
    endtask

    // Drives one request, holds it until a response pulse (bounded), observes one
    // extra cycle for pulse width, and updates the model.
    task automatic run_txn(input int w, input logic [29:0] a, input logic wr, input logic [3:0] bs,
                           input logic [31:0] v, output int lat, output int pulses,
                           output logic ack, output logic err, output logic [31:0] data,
                           output logic both, output logic ok, output logic [31:0] exp_data,
                           output logic [31:0] mask);
        logic a_s, e_s;
        @(negedge clk);
        set_req(w, 1'b1, a, wr, bs, v);
        lat = -1; pulses = 0; ack = 1'b0; err = 1'b0; data = 32'h0; both = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            a_s = get_ack(w);
            e_s = get_err(w);
            if (a_s && e_s) both = 1'b1;
            if (a_s || e_s) begin
                pulses++;
                if (lat < 0) begin
                    lat = c; ack = a_s; err = e_s; data = get_data(w);
                end
            end
            if (lat > 0 && c == lat) set_req(w, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
            if (lat > 0 && c == lat + 1) break;
        end
        set_req(w, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        model_apply(w, a, wr, bs, v, ok, exp_data, mask);
        $display("txn dut=%0d addr=%08h wr=%0d bs=%h val=%08h -> ack=%0d err=%0d data=%08h lat=%0d",
                 w, a, wr, bs, v, ack, err, data, lat);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int w = 0; w < 3; w++) set_req(w, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            checks++; if (get_ack(w) !== 1'b0) begin failures++; $display("FAIL reset_ack dut=%0d got=%b want=0", w, get_ack(w)); end
            checks++; if (get_err(w) !== 1'b0) begin failures++; $display("FAIL reset_err dut=%0d got=%b want=0", w, get_err(w)); end
            checks++; if (get_data(w) !== 32'h0) begin failures++; $display("FAIL reset_data dut=%0d got=%h want=0", w, get_data(w)); end
            checks++; if (get_busy(w) !== 1'b0) begin failures++; $display("FAIL reset_busy dut=%0d got=%b want=0", w, get_busy(w)); end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read;
        int lat, pulses; logic ack, err, both, ok; logic [31:0] data, ed, mk;
        run_txn(0, 30'h004, 1'b1, 4'hf, 32'hdeadbeef, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (ack !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL wr_full_resp got ack=%b err=%b want ack=1 err=0", ack, err); end
        checks++; if (lat != 2 || pulses != 1) begin failures++; $display("FAIL wr_full_timing got lat=%0d pulses=%0d want lat=2 pulses=1", lat, pulses); end
        run_txn(0, 30'h004, 1'b0, 4'hf, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (data !== 32'hdeadbeef) begin failures++; $display("FAIL rd_full_data got=%h want=deadbeef", data); end
        checks++; if (ack !== 1'b1 || lat != 2 || pulses != 1) begin failures++; $display("FAIL rd_full_resp got ack=%b lat=%0d pulses=%0d want 1/2/1", ack, lat, pulses); end
        run_txn(0, 30'h004, 1'b1, 4'b0010, 32'h0000aa00, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_lane_ack got=%b want=1", ack); end
        run_txn(0, 30'h004, 1'b0, 4'b0001, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (data !== 32'hdeadaaef) begin failures++; $display("FAIL rd_lane_data got=%h want=deadaaef", data); end
    endtask

    task automatic test_window;
        int lat, pulses; logic ack, err, both, ok; logic [31:0] data, ed, mk;
        run_txn(0, 30'h000, 1'b1, 4'hf, 32'h0badf00d, lat, pulses, ack, err, data, both, ok, ed, mk);
        run_txn(0, 30'h400, 1'b0, 4'hf, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (err !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL oow_resp got ack=%b err=%b want ack=0 err=1", ack, err); end
        checks++; if (data !== 32'h0) begin failures++; $display("FAIL oow_data got=%h want=0", data); end
        checks++; if (lat != 2 || pulses != 1 || both) begin failures++; $display("FAIL oow_timing got lat=%0d pulses=%0d both=%b want 2/1/0", lat, pulses, both); end
        run_txn(0, 30'h000, 1'b0, 4'h0, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (ack !== 1'b1 || data !== 32'h0badf00d) begin failures++; $display("FAIL after_oow_read got ack=%b data=%h want ack=1 data=0badf00d", ack, data); end
    endtask

    task automatic test_write_errors;
        int lat, pulses; logic ack, err, both, ok; logic [31:0] data, ed, mk, old;
        // read-only instance: contents never written, so compare against its own earlier read
        run_txn(1, 30'h010, 1'b0, 4'hf, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        old = data;
        checks++; if (ack !== 1'b1 || lat != 3) begin failures++; $display("FAIL ro_read_resp got ack=%b lat=%0d want ack=1 lat=3", ack, lat); end
        run_txn(1, 30'h010, 1'b1, 4'hf, 32'h55aa55aa, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (err !== 1'b1 || ack !== 1'b0 || data !== 32'h0) begin failures++; $display("FAIL ro_write_err got ack=%b err=%b data=%h want ack=0 err=1 data=0", ack, err, data); end
        run_txn(1, 30'h010, 1'b0, 4'hf, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (data !== old) begin failures++; $display("FAIL ro_unchanged got=%h want=%h", data, old); end
        run_txn(0, 30'h010, 1'b1, 4'hf, 32'h12345678, lat, pulses, ack, err, data, both, ok, ed, mk);
        run_txn(0, 30'h010, 1'b1, 4'h0, 32'hffffffff, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (err !== 1'b1 || ack !== 1'b0) begin failures++; $display("FAIL bs0_write_err got ack=%b err=%b want ack=0 err=1", ack, err); end
        run_txn(0, 30'h010, 1'b0, 4'hf, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (data !== 32'h12345678) begin failures++; $display("FAIL bs0_unchanged got=%h want=12345678", data); end
    endtask

    task automatic test_reset_in_wait;
        int lat, pulses, seen; logic ack, err, both, ok; logic [31:0] data, ed, mk;
        run_txn(0, 30'h020, 1'b1, 4'hf, 32'hcafe0020, lat, pulses, ack, err, data, both, ok, ed, mk);
        @(negedge clk);
        set_req(0, 1'b1, 30'h020, 1'b1, 4'hf, 32'h11111111);
        @(negedge clk);
        checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL wait_busy got=%b want=1", busy0); end
        rst = 1'b1;
        #1;
        checks++; if ({if0.d_ack, if0.d_error, busy0} !== 3'b000 || if0.d_data !== 32'h0) begin failures++; $display("FAIL rst_in_wait_outputs got ack=%b err=%b busy=%b data=%h want all 0", if0.d_ack, if0.d_error, busy0, if0.d_data); end
        seen = 0;
        @(negedge clk);
        if (if0.d_ack || if0.d_error) seen++;
        set_req(0, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (if0.d_ack || if0.d_error) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL rst_in_wait_pulse got=%0d pulses want=0", seen); end
        run_txn(0, 30'h020, 1'b0, 4'hf, 32'h0, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (data !== 32'hcafe0020) begin failures++; $display("FAIL rst_in_wait_mem got=%h want=cafe0020", data); end
    endtask

    task automatic test_back_to_back;
        int lat, pulses; logic ack, err, both, ok; logic [31:0] data, ed, mk;
        logic [4:1] ack_v, busy_v; logic [31:0] d1, d3;
        run_txn(2, 30'h800, 1'b1, 4'hf, 32'haaaa0800, lat, pulses, ack, err, data, both, ok, ed, mk);
        checks++; if (lat != 1 || ack !== 1'b1) begin failures++; $display("FAIL ws0_write got lat=%0d ack=%b want lat=1 ack=1", lat, ack); end
        run_txn(2, 30'h801, 1'b1, 4'hf, 32'hbbbb0801, lat, pulses, ack, err, data, both, ok, ed, mk);
        @(negedge clk);
        set_req(2, 1'b1, 30'h800, 1'b0, 4'hf, 32'h0);
        d1 = 32'h0; d3 = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            ack_v[c] = if2.d_ack;
            busy_v[c] = busy2;
            if (c == 1) begin d1 = if2.d_data; set_req(2, 1'b1, 30'h801, 1'b0, 4'hf, 32'h0); end
            if (c == 3) begin d3 = if2.d_data; set_req(2, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0); end
        end
        $display("txn dut=2 back-to-back reads 800/801 -> ack=%b busy=%b d1=%08h d3=%08h", ack_v, busy_v, d1, d3);
        checks++; if (ack_v !== 4'b0101) begin failures++; $display("FAIL b2b_ack cycles4..1 got=%b want=0101", ack_v); end
        checks++; if (busy_v !== 4'b0101) begin failures++; $display("FAIL b2b_busy cycles4..1 got=%b want=0101", busy_v); end
        checks++; if (d1 !== 32'haaaa0800 || d3 !== 32'hbbbb0801) begin failures++; $display("FAIL b2b_data got %h/%h want aaaa0800/bbbb0801", d1, d3); end
    endtask

    task automatic test_random;
        int lat, pulses, size, sel; logic ack, err, both, ok; logic [31:0] data, ed, mk, v;
        logic [29:0] a; logic wr; logic [3:0] bs;
        for (int n = 0; n < 120; n++) begin
            int w;
            w = n % 3;
            size = 1 << cfg_ab[w];
            sel = int'($urandom_range(0, 9));
            if (sel < 7) a = cfg_base[w] + 30'($urandom_range(0, 15));
            else if (sel == 7) a = cfg_base[w] + 30'(size);
            else if (sel == 8) a = cfg_base[w] - 30'd1;
            else a = 30'($urandom);
            wr = 1'($urandom_range(0, 1));
            bs = 4'($urandom_range(0, 15));
            v = $urandom;
            run_txn(w, a, wr, bs, v, lat, pulses, ack, err, data, both, ok, ed, mk);
            checks++; if (ack !== ok || err !== !ok) begin failures++; $display("FAIL rnd_resp dut=%0d addr=%h got ack=%b err=%b want ack=%b err=%b", w, a, ack, err, ok, !ok); end
            checks++; if (lat != cfg_ws[w] + 1 || pulses != 1 || both) begin failures++; $display("FAIL rnd_timing dut=%0d got lat=%0d pulses=%0d both=%b want lat=%0d pulses=1", w, lat, pulses, both, cfg_ws[w] + 1); end
            if (mk != 32'h0) begin
                checks++; if ((data & mk) !== (ed & mk)) begin failures++; $display("FAIL rnd_data dut=%0d addr=%h got=%h want=%h mask=%h", w, a, data, ed, mk); end
            end
        end
    endtask

    initial begin
        for (int w = 0; w < 3; w++) set_req(w, 1'b0, 30'h0, 1'b0, 4'h0, 32'h0);
        test_reset();
        test_write_read();
        test_window();
        test_write_errors();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
